// File: rtl/alu_share_arbiter.sv
// Two-requester shared ALU: round-robin grant, single-cycle add/sub/and,
// four-cycle shift-add multiply, one-cycle DONE pulse with owner id.
module alu_share_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    input  logic [1:0] s0,
    input  logic [1:0] s1,
    output logic       ack0,
    output logic       ack1,
    output logic       busy,
    output logic [7:0] y,
    output logic       done,
    output logic       done_id
);

    localparam int unsigned OPW = 4;
    localparam int unsigned RW  = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_next;
    logic            ptr;
    logic            owner;
    logic [1:0]      op_s;
    logic [1:0]      cnt;
    logic [RW-1:0]   mcand;
    logic [OPW-1:0]  mplr;
    logic [RW-1:0]   acc;

    logic            grant;
    logic            gid;
    logic            calc_last;
    logic [RW-1:0]   mul_sum;
    logic [RW-1:0]   result;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Arbitration, ack pulses and next-state selection
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        gid        = 1'b0;
        ack0       = 1'b0;
        ack1       = 1'b0;
        if (state == IDLE) begin
            grant = req0 | req1;
            gid   = (req0 && req1) ? ptr : req1;
            ack0  = grant & ~gid;
            ack1  = grant & gid;
        end
        case (state)
            IDLE:    if (grant) state_next = CALC;
            CALC:    if (calc_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result of the current CALC cycle; multiply adds one partial product per cycle
    always_comb begin
        calc_last = (op_s != OP_MUL) || (cnt == 2'd3);
        mul_sum   = acc + (mplr[0] ? mcand : RW'(0));
        case (op_s)
            OP_ADD:  result = mcand + RW'(mplr);
            OP_SUB:  result = mcand - RW'(mplr);
            OP_MUL:  result = mul_sum;
            default: result = RW'(mcand[OPW-1:0] & mplr);
        endcase
    end

    // Operand capture, multiply sequencing, pointer and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr     <= 1'b0;
            owner   <= 1'b0;
            op_s    <= 2'b00;
            cnt     <= 2'd0;
            mcand   <= '0;
            mplr    <= '0;
            acc     <= '0;
            y       <= '0;
            done    <= 1'b0;
            done_id <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done <= 1'b0;
            busy <= (state_next != IDLE);
            if (grant) begin
                ptr   <= ~gid;
                owner <= gid;
                op_s  <= gid ? s1 : s0;
                mcand <= RW'(gid ? a1 : a0);
                mplr  <= gid ? b1 : b0;
                acc   <= '0;
                cnt   <= 2'd0;
            end
            if (state == CALC && op_s == OP_MUL) begin
                acc   <= mul_sum;
                mcand <= mcand << 1;
                mplr  <= mplr >> 1;
                cnt   <= cnt + 2'd1;
            end
            if (state == CALC && calc_last) begin
                y       <= result;
                done    <= 1'b1;
                done_id <= owner;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios with literal results plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_alu_share_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0] s0 = '0, s1 = '0;
    logic       ack0, ack1, busy, done, done_id;
    logic [7:0] y;

    int n_tests = 0;
    int n_fail  = 0;
    int ncyc    = 0;

    alu_share_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .s0(s0), .s1(s1),
        .ack0(ack0), .ack1(ack1), .busy(busy), .y(y),
        .done(done), .done_id(done_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, ncyc);
        end
    endtask

    function automatic logic [7:0] ref_op(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] s);
        int ia, ib, r;
        ia = int'(a);
        ib = int'(b);
        case (s)
            2'b00:   r = ia + ib;
            2'b01:   r = ia - ib;
            2'b10:   r = ia * ib;
            default: r = ia & ib;
        endcase
        return 8'(r);
    endfunction

    // Transaction-level model: one op in flight, finishing at a known cycle
    logic       m_valid = 1'b0;
    logic       m_active = 1'b0;
    logic       m_ptr = 1'b0;
    logic       m_id = 1'b0;
    logic [7:0] m_res = '0;
    logic [7:0] m_y = '0;
    int         m_done_cyc = 0;
    int         m_cyc = 0;
    logic       e_grant, e_gid, e_done;

    always @(negedge clk) begin
        e_grant = !m_active && (req0 || req1);
        e_gid   = (req0 && req1) ? m_ptr : req1;
        e_done  = m_active && (m_cyc == m_done_cyc);
        if (m_valid) begin
            check("ack0", 32'(ack0), 32'(e_grant && !e_gid));
            check("ack1", 32'(ack1), 32'(e_grant && e_gid));
            check("busy", 32'(busy), 32'(m_active));
            check("done", 32'(done), 32'(e_done));
            if (e_done) begin
                check("y_done", 32'(y), 32'(m_res));
                check("done_id", 32'(done_id), 32'(m_id));
            end else begin
                check("y_hold", 32'(y), 32'(m_y));
            end
        end
        if (!rst_n) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_ptr    = 1'b0;
            m_y      = 8'h00;
        end else if (m_valid) begin
            if (e_done) begin
                m_active = 1'b0;
                m_y      = m_res;
            end else if (e_grant) begin
                m_active   = 1'b1;
                m_id       = e_gid;
                m_ptr      = !e_gid;
                m_res      = e_gid ? ref_op(a1, b1, s1) : ref_op(a0, b0, s0);
                m_done_cyc = m_cyc + (((e_gid ? s1 : s0) == 2'b10) ? 5 : 2);
            end
        end
        m_cyc++;
    end

    // Issue one op from requester id, drop req after ack, check literal result and latency
    task automatic do_op(input logic id, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] s, input logic [7:0] ey, input int lat,
                         input string nm);
        int  t_ack;
        logic got;
        t_ack = 0;
        @(posedge clk); #1;
        if (id) begin req1 = 1'b1; a1 = a; b1 = b; s1 = s; end
        else    begin req0 = 1'b1; a0 = a; b0 = b; s0 = s; end
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (id ? ack1 : ack0) begin got = 1'b1; t_ack = ncyc; end
        end
        check({nm, "_ack"}, 32'(got), 32'd1);
        @(posedge clk); #1;
        if (id) req1 = 1'b0; else req0 = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check({nm, "_done"}, 32'(got), 32'd1);
        check({nm, "_lat"}, 32'(ncyc - t_ack), 32'(lat));
        check({nm, "_y"}, 32'(y), 32'(ey));
        check({nm, "_id"}, 32'(done_id), 32'(id));
        check({nm, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) @(posedge clk);
        #1;
    endtask

    task automatic step_req(input logic r, input logic k, output logic nr, output logic fresh);
        fresh = 1'b0;
        nr    = r;
        if (r && k) begin
            nr    = 1'($urandom % 2);
            fresh = nr;
        end else if (r) begin
            if ($urandom % 20 == 0) nr = 1'b0;
        end else if ($urandom % 3 == 0) begin
            nr    = 1'b1;
            fresh = 1'b1;
        end
    endtask

    initial begin
        int   acks [$];
        int   ids  [$];
        int   dcount;
        logic k0, k1, nr, fresh;

        // Reset and reset-state literals
        rst_n = 1'b0;
        idle_cycles(2);
        @(negedge clk);
        check("rst_y", 32'(y), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_id", 32'(done_id), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Round robin with both requesters held high, single-cycle adds
        req0 = 1'b1; a0 = 4'd1; b0 = 4'd2; s0 = 2'b00;
        req1 = 1'b1; a1 = 4'd3; b1 = 4'd4; s1 = 2'b00;
        for (int k = 0; k < 30 && acks.size() < 4; k++) begin
            @(negedge clk);
            if (ack0 || ack1) begin acks.push_back(ncyc); ids.push_back(int'(ack1)); end
        end
        check("rr_count", 32'(acks.size()), 32'd4);
        if (acks.size() == 4) begin
            for (int i = 0; i < 4; i++) check("rr_order", 32'(ids[i]), 32'(i % 2));
            for (int i = 1; i < 4; i++) check("rr_gap", 32'(acks[i] - acks[i-1]), 32'd3);
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        idle_cycles(4);

        // Directed single ops with hand-computed results
        do_op(1'b0, 4'd9, 4'd6, 2'b00, 8'h0F, 2, "add");
        idle_cycles(2);
        do_op(1'b1, 4'd3, 4'd5, 2'b01, 8'hFE, 2, "sub");
        idle_cycles(2);
        do_op(1'b1, 4'hC, 4'hA, 2'b11, 8'h08, 2, "and");
        idle_cycles(2);

        // Multiply with req1 also pending: pointer is 0 so requester 0 wins
        req1 = 1'b1; a1 = 4'd2; b1 = 4'd2; s1 = 2'b00;
        do_op(1'b0, 4'd15, 4'd15, 2'b10, 8'hE1, 5, "mul");
        @(posedge clk); #1;
        req1 = 1'b0;
        idle_cycles(5);

        // Reset in the middle of a multiply
        @(posedge clk); #1;
        req0 = 1'b1; a0 = 4'd7; b0 = 4'd9; s0 = 2'b10;
        k0 = 1'b0;
        for (int k = 0; k < 10 && !k0; k++) begin
            @(negedge clk);
            k0 = ack0;
        end
        check("mrst_ack", 32'(k0), 32'd1);
        @(posedge clk); #1;
        req0 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        dcount = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("mrst_nodone", 32'(dcount), 32'd0);
        check("mrst_y", 32'(y), 32'h00);
        check("mrst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        req0 = 1'b1; req1 = 1'b1; s0 = 2'b00; s1 = 2'b00;
        @(negedge clk);
        check("mrst_grant0", 32'({ack1, ack0}), 32'b01);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        idle_cycles(4);

        // Randomized traffic, including occasional withdrawals and resets
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            k0 = ack0;
            k1 = ack1;
            @(posedge clk); #1;
            step_req(req0, k0, nr, fresh);
            req0 = nr;
            if (fresh) begin a0 = 4'($urandom); b0 = 4'($urandom); s0 = 2'($urandom); end
            step_req(req1, k1, nr, fresh);
            req1 = nr;
            if (fresh) begin a1 = 4'($urandom); b1 = 4'($urandom); s1 = 2'($urandom); end
            rst_n = ($urandom % 150 != 0);
        end
        rst_n = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        idle_cycles(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 req0 / req1  input  1 each  operation request from requester 0 / 1; held high until the matching ack.
REQ-004 a0, b0 / a1, b1  input  4 each  unsigned operands for requester 0 / 1; sampled only in the ack cycle.
REQ-005 s0 / s1  input  2 each  opcode for requester 0 / 1: 00 add, 01 subtract, 10 multiply, 11 bitwise AND.
REQ-006 ack0 / ack1  output  1 each  one-cycle accept pulse; operands and opcode are captured in this cycle.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 y  output  8  result of the last completed operation.
REQ-009 done  output  1  one-cycle pulse; y is valid in this cycle.
REQ-010 done_id  output  1  requester that owns the result; valid with done.

Function
REQ-011 The block SHALL use the states IDLE, CALC and DONE.
REQ-012 In IDLE with at least one req high, the block SHALL grant exactly one requester, pulse its ack, latch its a, b and s, and go to CALC.
REQ-013 Arbitration SHALL be round-robin.
- A single requester is granted directly.
- When both requesters are high, the one selected by the priority pointer is granted.
- On every grant, the pointer SHALL move to the other requester.
- The pointer is 0 after reset.
REQ-014 Outside IDLE, req inputs SHALL be ignored and ack0/ack1 SHALL stay low.
REQ-015 At most one ack SHALL be high in any cycle.
REQ-016 Opcodes 00, 01 and 11 SHALL take exactly one CALC cycle.
REQ-017 Opcode 10 SHALL take exactly four CALC cycles using an internal shift-add sequence, one multiplier bit per cycle, LSB first.
REQ-018 Result arithmetic (all modulo 256):
- add: {4'b0,a} + {4'b0,b}
- subtract: {4'b0,a} - {4'b0,b}, so a negative result gives the two's-complement 8-bit value
- multiply: full 8-bit unsigned product
- AND: {4'b0, a & b}
REQ-019 After the last CALC cycle, the block SHALL enter DONE for one cycle and then return to IDLE.
- In DONE: y is updated, done = 1, and done_id = the granted requester.
REQ-020 Latency from the ack cycle to the done cycle SHALL be 2 cycles for opcodes 00, 01 and 11, and 5 cycles for opcode 10.
REQ-021 y SHALL hold its value between done pulses; partial multiply products SHALL NOT appear on y.
REQ-022 A new grant SHALL be possible in the first IDLE cycle after DONE, so there are no idle bubbles beyond the DONE→IDLE cycle.
REQ-023 A requester dropping req before its ack SHALL simply not be granted; a req withdrawn after its ack SHALL NOT affect the operation in flight.

Reset
REQ-024 While rst_n is low at a rising edge, the block SHALL enter IDLE and set the following:
- pointer = 0
- y = 8'h00
- done = 0, done_id = 0
- ack0 = ack1 = 0
- busy = 0
- internal operand, opcode and multiply registers = 0
REQ-025 Reset during CALC or DONE SHALL abort the operation with no done pulse; arbitration restarts normally after rst_n returns high.

Verification
REQ-026 Add: req0, a0=9, b0=6, s0=00 → ack0 in cycle T; at T+2, done=1, done_id=0, y=8'h0F.
REQ-027 Subtract: req1, a1=3, b1=5, s1=01 → ack1 in cycle T; at T+2, done=1, done_id=1, y=8'hFE.
REQ-028 Multiply: req0, a0=15, b0=15, s0=10 → ack0 in cycle T; done only at T+5, y=8'hE1; busy high from T+1 to T+5; no ack during the operation even with req1 high.
REQ-029 Round-robin after reset: req0 and req1 both held high continuously → grant order 0, 1, 0, 1; each ack exactly one cycle, successive acks 3 cycles apart for single-cycle ops.
REQ-030 AND: req1, a1=4'hC, b1=4'hA, s1=11 → y=8'h08 and done_id=1 at T+2.
REQ-031 Reset mid-multiply: rst_n low for one edge at T+2 of a multiply → no done ever; y=8'h00; busy=0; the next dual request grants requester 0.
